// File: rtl/debounce_pkg.sv
// Shared types, constants and helpers for the multi-channel debounce filter.
package debounce_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  // Counter width for a given stability limit, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debounce: optional 2-flop synchroniser (DEBOUNCE_MULTI_SYNC_EN),
// stability counter FSM and registered rise/fall strobe generation.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned LIMIT   = 250000,
  parameter logic        RST_BIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bouncy,
  output logic o_debounced,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge_c
);

  localparam int unsigned     CNT_W   = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

  logic             w_s_in;
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_deb;
  logic             w_deb_nxt;
  logic             r_prev;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

`ifdef DEBOUNCE_MULTI_SYNC_EN
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {SYNC_STAGES{RST_BIT}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_bouncy};
  end

  assign w_s_in = r_sync[SYNC_STAGES-1];
`else
  assign w_s_in = i_bouncy;
`endif

  // A channel in ST_STABLE always counts from zero, whatever r_cnt holds.
  assign w_cnt_cur = (r_state == ST_COUNTING) ? r_cnt : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_deb   <= RST_BIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_deb   <= w_deb_nxt;
    end
  end

  // Any cycle where input matches output cancels a pending change.
  always_comb begin
    w_state_nxt = ST_STABLE;
    w_cnt_nxt   = '0;
    w_deb_nxt   = r_deb;
    if (w_s_in != r_deb) begin
      if (w_cnt_cur == CNT_MAX) begin
        w_deb_nxt = w_s_in;
      end else begin
        w_state_nxt = ST_COUNTING;
        w_cnt_nxt   = w_cnt_cur + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_rise_nxt = r_deb & ~r_prev;
    w_fall_nxt = ~r_deb & r_prev;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= RST_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= r_deb;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign o_debounced = r_deb;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_edge_c    = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/debounce_multi.sv
// NUM_CH independent debounce channels with per-channel edge strobes and a
// combined change flag. Input synchroniser enabled by DEBOUNCE_MULTI_SYNC_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned         NUM_CH         = 4,
  parameter int unsigned         DEBOUNCE_LIMIT = 250000,
  parameter logic [NUM_CH-1:0]   RESET_VAL      = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_bouncy,
  output logic [NUM_CH-1:0] o_debounced,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic              o_any_change
);

  logic [NUM_CH-1:0] w_edge;
  logic              r_any;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .LIMIT   (DEBOUNCE_LIMIT),
      .RST_BIT (RESET_VAL[g])
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_bouncy    (i_bouncy[g]),
      .o_debounced (o_debounced[g]),
      .o_rise      (o_rise[g]),
      .o_fall      (o_fall[g]),
      .o_edge_c    (w_edge[g])
    );
  end

  // Registered from the strobes' next values so it lines up with o_rise/o_fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_any <= 1'b0;
    else          r_any <= |w_edge;
  end

  assign o_any_change = r_any;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (NUM_CH=4, DEBOUNCE_LIMIT=4, RESET_VAL=0).
module tb_debounce_multi;
  import debounce_pkg::*;

  localparam int unsigned LIMIT = 4;
`ifdef DEBOUNCE_MULTI_SYNC_EN
  localparam int unsigned LAT = LIMIT + SYNC_STAGES;
`else
  localparam int unsigned LAT = LIMIT;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] bouncy;
  logic [3:0] deb;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any;

  int n_vec = 0;
  int n_err = 0;

  debounce_multi #(
    .NUM_CH         (4),
    .DEBOUNCE_LIMIT (LIMIT),
    .RESET_VAL      (4'b0000)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_bouncy     (bouncy),
    .o_debounced  (deb),
    .o_rise       (rise),
    .o_fall       (fall),
    .o_any_change (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:19] glitch_pat;
    glitch_pat = 20'b1110_1110_0010_1010_1010;

    // Reset with all inputs high: nothing may propagate.
    rst_n  = 1'b0;
    bouncy = 4'hF;
    repeat (3) tick();
    check("rst_deb",  32'(deb),  32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_any",  32'(any),  32'h0);

    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    check("rel_deb_early",  32'(deb),  32'h0);
    check("rel_rise_early", 32'(rise), 32'h0);
    tick();
    check("rel_deb", 32'(deb), 32'hF);
    tick();
    check("rel_rise", 32'(rise), 32'hF);
    check("rel_any",  32'(any),  32'h1);
    tick();
    check("rel_rise_end", 32'(rise), 32'h0);
    check("rel_any_end",  32'(any),  32'h0);

    // Return all channels low; fall strobes on all four.
    bouncy = 4'h0;
    repeat (LAT) tick();
    check("clr_deb", 32'(deb), 32'h0);
    tick();
    check("clr_fall", 32'(fall), 32'hF);
    check("clr_any",  32'(any),  32'h1);
    tick();

    // Glitches (3 high, 1 low) and per-cycle toggling on ch0 never pass.
    for (int i = 0; i < 20; i++) begin
      bouncy[0] = glitch_pat[i];
      tick();
      check("glitch_deb",  32'(deb),  32'h0);
      check("glitch_rise", 32'(rise), 32'h0);
    end
    bouncy = 4'h0;
    repeat (LAT + 2) tick();
    check("glitch_final", 32'(deb), 32'h0);

    // Stable rise on ch1.
    bouncy = 4'b0010;
    repeat (LAT - 1) tick();
    check("rise_deb_early", 32'(deb), 32'h0);
    tick();
    check("rise_deb",     32'(deb),  32'h2);
    check("rise_no_strb", 32'(rise), 32'h0);
    tick();
    check("rise_strb", 32'(rise), 32'h2);
    check("rise_any",  32'(any),  32'h1);
    tick();
    check("rise_strb_end", 32'(rise), 32'h0);
    check("rise_any_end",  32'(any),  32'h0);

    // Bring ch3 high, then ch2 rises while ch3 falls in the same cycle.
    bouncy = 4'b1010;
    repeat (LAT + 2) tick();
    check("sim_pre", 32'(deb), 32'hA);
    bouncy = 4'b0110;
    repeat (LAT) tick();
    check("sim_deb",    32'(deb),  32'h6);
    check("sim_rise_0", 32'(rise), 32'h0);
    tick();
    check("sim_rise", 32'(rise), 32'h4);
    check("sim_fall", 32'(fall), 32'h8);
    check("sim_any",  32'(any),  32'h1);
    tick();
    check("sim_rise_end", 32'(rise), 32'h0);
    check("sim_fall_end", 32'(fall), 32'h0);

    // Asynchronous reset in the middle of a ch1 count.
    bouncy = 4'b0100;
    repeat (LAT + 2) tick();
    check("mid_pre", 32'(deb), 32'h4);
    bouncy = 4'b0110;
    repeat (LAT - 2) tick();
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_deb", 32'(deb), 32'h0);
    check("mid_rst_any", 32'(any), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    check("mid_deb_early", 32'(deb), 32'h0);
    tick();
    check("mid_deb", 32'(deb), 32'h6);
    tick();
    check("mid_rise", 32'(rise), 32'h6);
    check("mid_any",  32'(any),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel successor to the single-input debounce filter.
- Filters NUM_CH independent bouncy inputs (switches/buttons), each with its own stability counter.
- Adds an optional input synchroniser, per-channel one-cycle rise/fall strobes and a programmable reset level.
- Sits between board pins and user logic (LED/7-seg/FSM projects).

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive clocks an input must differ from the current output before the output flips (>=2; 10 ms at 25 MHz).
- RESET_VAL, '0 (NUM_CH bits), per-channel value of o_debounced, synchroniser flops and the previous-state register in reset.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_bouncy  in  NUM_CH  raw asynchronous switch inputs.
- o_debounced  out  NUM_CH  filtered level per channel.
- o_rise  out  NUM_CH  one-cycle strobe when o_debounced[n] goes 0->1.
- o_fall  out  NUM_CH  one-cycle strobe when o_debounced[n] goes 1->0.
- o_any_change  out  1  OR-reduction of o_rise|o_fall, registered with them.

Behaviour:
- Reset is asynchronous, active-low. While i_rst_n=0: o_debounced=RESET_VAL, counters=0, o_rise=o_fall=0, o_any_change=0, synchroniser flops=RESET_VAL.
- Per channel, s_in[n] is the synchronised input (or i_bouncy[n] when the sync stage is compiled out).
- Counter width: CNT_W = max(1, $clog2(DEBOUNCE_LIMIT)). Unsigned. Never exceeds DEBOUNCE_LIMIT-1.
- Per-channel FSM:
  - STABLE: s_in==o_debounced, count=0.
  - COUNTING: s_in!=o_debounced.
- Each clock:
  - If s_in==o_debounced: count<=0 and the channel returns to STABLE. A single matching cycle fully cancels a pending change (glitch rejection).
  - If s_in!=o_debounced and count<DEBOUNCE_LIMIT-1: count<=count+1.
  - If s_in!=o_debounced and count==DEBOUNCE_LIMIT-1: o_debounced<=s_in, count<=0.
- Filter latency: o_debounced changes exactly DEBOUNCE_LIMIT clocks after s_in first differs, provided s_in holds for all of them.
- Edge strobes:
  - A prev register holds the last o_debounced.
  - o_rise = o_debounced & ~prev and o_fall = ~o_debounced & prev, both registered. They assert on the clock after o_debounced changes, for exactly 1 cycle.
  - No strobe fires at reset release, because prev resets to RESET_VAL.
- Channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle; o_any_change=1 for that cycle.
- Reset mid-count: the counter is cleared immediately. After release, a full DEBOUNCE_LIMIT stable period is required.
- Input toggling every cycle: the output never changes.

Optional Feature:
- Macro DEBOUNCE_MULTI_SYNC_EN.
- Defined: a 2-flop synchroniser per channel precedes the filter. Total latency i_bouncy -> o_debounced = DEBOUNCE_LIMIT+2 clocks; strobes one clock later.
- Undefined: i_bouncy feeds the filter directly. Latency = DEBOUNCE_LIMIT clocks. Intended only for inputs that are already synchronous.

Decomposition:
- Package debounce_pkg contains:
  - function cnt_width(limit), returning max(1, clog2(limit));
  - enum typedef deb_state_e {ST_STABLE, ST_COUNTING};
  - localparam SYNC_STAGES=2.
- Sub-module debounce_channel: one synchroniser + counter + FSM + edge register for a single bit.
- debounce_multi instantiates it NUM_CH times via generate and ORs the strobes.

Test Plan (NUM_CH=4, DEBOUNCE_LIMIT=4, RESET_VAL=4'b0000, sync enabled):
- Reset: i_rst_n=0 with i_bouncy=4'hF -> o_debounced=0, o_rise=o_fall=0. After release, no strobe until input has been stable 4 cycles post-sync.
- Glitch: ch0 high 3 clocks, low 1 clock, high 3 clocks, then low -> o_debounced[0] stays 0, o_rise[0] never asserts.
- Stable rise: ch1 held high from edge T -> o_debounced[1]=1 at T+6; o_rise[1]=1 only at T+7; o_any_change=1 at T+7.
- Simultaneous: ch2 rises while ch3 falls (ch3 previously debounced high) -> o_rise[2] and o_fall[3] pulse in the same cycle; other channels are unaffected.
- Reset mid-count: ch1 high for 2 cycles post-sync, pulse i_rst_n low asynchronously (between edges) -> outputs immediately 0. After release, ch1 must hold 4+2 cycles before o_debounced[1]=1.
- Sync compiled out (DEBOUNCE_MULTI_SYNC_EN undefined): repeat the stable-rise test -> o_debounced[1]=1 at T+4.
